// File: rtl/fp_div_special_pipe.sv
// Special-operand front end for the iterative divider: classifies operand pairs,
// resolves NaN/Inf/Zero quotients and forwards everything else to the core.
module fp_div_special_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4,
    parameter int DAZ   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_special,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [EXP_W+MAN_W:0]   out_a,
    output logic [EXP_W+MAN_W:0]   out_b,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_invalid,
    output logic                   out_divzero,
    output logic                   out_denorm,
    input  logic                   flags_clr,
    output logic                   sticky_invalid,
    output logic                   sticky_divzero
);
    localparam int W = 1 + EXP_W + MAN_W;

    typedef enum logic [2:0] {CL_NORM, CL_SUB, CL_ZERO, CL_INF, CL_NAN} cls_t;

    localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic is_sub(input logic [W-1:0] x);
        return (x[W-2 -: EXP_W] == '0) && (x[MAN_W-1:0] != '0);
    endfunction

    function automatic cls_t classify(input logic [W-1:0] x);
        cls_t c;
        c = CL_NORM;
        if (&x[W-2 -: EXP_W])
            c = (x[MAN_W-1:0] != '0) ? CL_NAN : CL_INF;
        else if (x[W-2 -: EXP_W] == '0) begin
            if (x[MAN_W-1:0] == '0)
                c = CL_ZERO;
            else
                c = (DAZ != 0) ? CL_ZERO : CL_SUB;
        end
        return c;
    endfunction

    // Flushed subnormals keep their sign so the quotient sign stays correct.
    function automatic logic [W-1:0] flush(input logic [W-1:0] x);
        return (DAZ != 0 && is_sub(x)) ? {x[W-1], {(W-1){1'b0}}} : x;
    endfunction

    logic             adv1, adv2;
    logic             s1_valid;
    logic [W-1:0]     s1_a, s1_b;
    logic [TAG_W-1:0] s1_tag;
    cls_t             s1_ca, s1_cb;
    logic             s1_denorm;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_tag    <= '0;
            s1_ca     <= CL_NORM;
            s1_cb     <= CL_NORM;
            s1_denorm <= 1'b0;
        end else if (adv1) begin
            s1_valid  <= in_valid;
            s1_a      <= flush(in_a);
            s1_b      <= flush(in_b);
            s1_tag    <= in_tag;
            s1_ca     <= classify(in_a);
            s1_cb     <= classify(in_b);
            s1_denorm <= is_sub(in_a) | is_sub(in_b);
        end
    end

    logic         sq;
    logic         r_special, r_invalid, r_divzero;
    logic [W-1:0] r_result;

    assign sq = s1_a[W-1] ^ s1_b[W-1];

    always_comb begin
        r_special = 1'b1;
        r_result  = '0;
        r_invalid = 1'b0;
        r_divzero = 1'b0;
        if (s1_ca == CL_NAN || s1_cb == CL_NAN) begin
            r_result  = QNAN;
            r_invalid = 1'b1;
        end else if (s1_ca == CL_INF && s1_cb == CL_INF) begin
            r_result  = QNAN;
            r_invalid = 1'b1;
        end else if (s1_ca == CL_ZERO && s1_cb == CL_ZERO) begin
            r_result  = QNAN;
            r_invalid = 1'b1;
        end else if (s1_ca == CL_INF) begin
            r_result  = {sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s1_cb == CL_INF) begin
            r_result  = {sq, {(W-1){1'b0}}};
        end else if (s1_ca == CL_ZERO) begin
            r_result  = {sq, {(W-1){1'b0}}};
        end else if (s1_cb == CL_ZERO) begin
            r_result  = {sq, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_divzero = 1'b1;
        end else begin
            r_special = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_special <= 1'b0;
            out_result  <= '0;
            out_a       <= '0;
            out_b       <= '0;
            out_tag     <= '0;
            out_invalid <= 1'b0;
            out_divzero <= 1'b0;
            out_denorm  <= 1'b0;
        end else if (adv2) begin
            out_valid   <= s1_valid;
            out_special <= r_special;
            out_result  <= r_result;
            out_a       <= s1_a;
            out_b       <= s1_b;
            out_tag     <= s1_tag;
            out_invalid <= r_invalid;
            out_divzero <= r_divzero;
            out_denorm  <= s1_denorm;
        end
    end

    logic hs;
    assign hs = out_valid & out_ready;

    // A clear coinciding with a new event must still leave the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_invalid <= 1'b0;
            sticky_divzero <= 1'b0;
        end else begin
            sticky_invalid <= (flags_clr ? 1'b0 : sticky_invalid) | (hs & out_invalid);
            sticky_divzero <= (flags_clr ? 1'b0 : sticky_divzero) | (hs & out_divzero);
        end
    end

endmodule

// File: tb/tb_fp_div_special_pipe.sv
// Bench for fp_div_special_pipe: table of vectors with a scoreboard queue,
// checking a DAZ=0 and a DAZ=1 instance side by side, plus stall/sticky/reset sequences.
module tb_fp_div_special_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, flags_clr;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        in_ready, out_valid, out_special, out_invalid, out_divzero, out_denorm;
    logic [31:0] out_result, out_a, out_b;
    logic [3:0]  out_tag;
    logic        sticky_invalid, sticky_divzero;

    logic        d_in_ready, d_out_valid, d_special, d_invalid, d_divzero, d_denorm;
    logic [31:0] d_result, d_a, d_b;
    logic [3:0]  d_tag;
    logic        d_sticky_invalid, d_sticky_divzero;

    always #5 clk = ~clk;

    fp_div_special_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4), .DAZ(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_special(out_special),
        .out_result(out_result), .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
        .out_invalid(out_invalid), .out_divzero(out_divzero), .out_denorm(out_denorm),
        .flags_clr(flags_clr), .sticky_invalid(sticky_invalid), .sticky_divzero(sticky_divzero)
    );

    fp_div_special_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4), .DAZ(1)) dut_daz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_special(d_special),
        .out_result(d_result), .out_a(d_a), .out_b(d_b), .out_tag(d_tag),
        .out_invalid(d_invalid), .out_divzero(d_divzero), .out_denorm(d_denorm),
        .flags_clr(flags_clr), .sticky_invalid(d_sticky_invalid), .sticky_divzero(d_sticky_divzero)
    );

    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  tag;
        logic        sp;
        logic [31:0] res;
        logic        inv, dz, dn;
        logic        sp1;
        logic [31:0] res1, a1, b1;
        logic        inv1, dz1;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];
    vec_t cur;
    vec_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sp,
                                input logic [31:0] res, input logic inv, input logic dz,
                                input logic dn);
        vec_t v;
        v.a = a; v.b = b; v.tag = 4'h0; v.sp = sp; v.res = res;
        v.inv = inv; v.dz = dz; v.dn = dn;
        v.sp1 = sp; v.res1 = res; v.a1 = a; v.b1 = b; v.inv1 = inv; v.dz1 = dz;
        return v;
    endfunction

    // Scoreboard: push on input handshake, pop on output handshake.
    logic        held_v = 1'b0;
    logic [31:0] h_res, h_a, h_b;
    logic [3:0]  h_tag;
    logic        h_sp;

    always @(negedge clk) begin
        vec_t e;
        if (rst) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(q.size() == 2 && !out_ready)});
            if (held_v) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_result", out_result, h_res);
                chk("hold_a", out_a, h_a);
                chk("hold_b", out_b, h_b);
                chk("hold_tag", {28'd0, out_tag}, {28'd0, h_tag});
                chk("hold_special", {31'd0, out_special}, {31'd0, h_sp});
            end
            held_v = out_valid && !out_ready;
            h_res = out_result; h_a = out_a; h_b = out_b; h_tag = out_tag; h_sp = out_special;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("tag", {28'd0, out_tag}, {28'd0, e.tag});
                    chk("special", {31'd0, out_special}, {31'd0, e.sp});
                    chk("result", out_result, e.res);
                    chk("fwd_a", out_a, e.a);
                    chk("fwd_b", out_b, e.b);
                    chk("invalid", {31'd0, out_invalid}, {31'd0, e.inv});
                    chk("divzero", {31'd0, out_divzero}, {31'd0, e.dz});
                    chk("denorm", {31'd0, out_denorm}, {31'd0, e.dn});
                    chk("daz_valid", {31'd0, d_out_valid}, 32'd1);
                    chk("daz_special", {31'd0, d_special}, {31'd0, e.sp1});
                    chk("daz_result", d_result, e.res1);
                    chk("daz_a", d_a, e.a1);
                    chk("daz_b", d_b, e.b1);
                    chk("daz_invalid", {31'd0, d_invalid}, {31'd0, e.inv1});
                    chk("daz_divzero", {31'd0, d_divzero}, {31'd0, e.dz1});
                    chk("daz_denorm", {31'd0, d_denorm}, {31'd0, e.dn});
                end
            end
            if (in_valid && in_ready) q.push_back(cur);
        end
    end

    task automatic set_in(input int i);
        cur      = vecs[i];
        in_valid = 1'b1;
        in_a     = vecs[i].a;
        in_b     = vecs[i].b;
        in_tag   = vecs[i].tag;
    endtask

    task automatic run_stream(input int first, input int n, input logic stall);
        logic [3:0] pat;
        int sent;
        int c;
        pat  = 4'b1001;
        sent = 0;
        c    = 0;
        forever begin
            @(posedge clk); #1;
            if (sent >= n && q.size() == 0) break;
            if (c >= 300) begin
                chk("stream_timeout", 32'd1, 32'd0);
                break;
            end
            out_ready = stall ? pat[c % 4] : 1'b1;
            if (sent < n) set_in(first + sent);
            else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        bit found;
        vecs[0]  = mk(32'h3F800000, 32'hC0000000, 0, 32'h00000000, 0, 0, 0);
        vecs[1]  = mk(32'h3F800000, 32'h80000000, 1, 32'hFF800000, 0, 1, 0);
        vecs[2]  = mk(32'h7FC00001, 32'h3F800000, 1, 32'hFFC00000, 1, 0, 0);
        vecs[3]  = mk(32'h7F800000, 32'hFF800000, 1, 32'hFFC00000, 1, 0, 0);
        vecs[4]  = mk(32'h00000000, 32'h00000000, 1, 32'hFFC00000, 1, 0, 0);
        vecs[5]  = mk(32'h00000001, 32'h3F800000, 0, 32'h00000000, 0, 0, 1);
        vecs[5].sp1 = 1; vecs[5].res1 = 32'h00000000; vecs[5].a1 = 32'h00000000;
        vecs[6]  = mk(32'h7F800000, 32'h3F800000, 1, 32'h7F800000, 0, 0, 0);
        vecs[7]  = mk(32'h3F800000, 32'hFF800000, 1, 32'h80000000, 0, 0, 0);
        vecs[8]  = mk(32'h80000000, 32'h40000000, 1, 32'h80000000, 0, 0, 0);
        vecs[9]  = mk(32'h40000000, 32'h7FC00000, 1, 32'hFFC00000, 1, 0, 0);
        vecs[10] = mk(32'h00400000, 32'h00000000, 1, 32'h7F800000, 0, 1, 1);
        vecs[10].res1 = 32'hFFC00000; vecs[10].inv1 = 1; vecs[10].dz1 = 0;
        vecs[10].a1 = 32'h00000000;
        vecs[11] = mk(32'h7F800000, 32'h00000000, 1, 32'h7F800000, 0, 0, 0);
        vecs[12] = mk(32'hC0400000, 32'h00000001, 0, 32'h00000000, 0, 0, 1);
        vecs[12].sp1 = 1; vecs[12].res1 = 32'hFF800000; vecs[12].dz1 = 1; vecs[12].b1 = 32'h00000000;
        vecs[13] = mk(32'h80000001, 32'h3F800000, 0, 32'h00000000, 0, 0, 1);
        vecs[13].sp1 = 1; vecs[13].res1 = 32'h80000000; vecs[13].a1 = 32'h80000000;
        vecs[14] = mk(32'hFF800000, 32'h00400000, 1, 32'hFF800000, 0, 0, 1);
        vecs[14].b1 = 32'h00000000;
        for (int i = 0; i < NV; i++) vecs[i].tag = i[3:0];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0; cur = vecs[0];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_sticky_inv", {31'd0, sticky_invalid}, 32'd0);
        chk("rst_sticky_dz", {31'd0, sticky_divzero}, 32'd0);

        // Two-cycle latency with out_ready held high.
        @(posedge clk); #1 set_in(0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("latency_cycle1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("latency_cycle2", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("latency_after", {31'd0, out_valid}, 32'd0);
        chk("no_flags_sticky", {30'd0, sticky_invalid, sticky_divzero}, 32'd0);

        run_stream(0, NV, 1'b0);
        chk("sticky_inv_set", {31'd0, sticky_invalid}, 32'd1);
        chk("sticky_dz_set", {31'd0, sticky_divzero}, 32'd1);
        chk("daz_sticky_inv_set", {31'd0, d_sticky_invalid}, 32'd1);

        run_stream(6, 5, 1'b1);

        // Clear racing a divzero handshake, then a clear on its own.
        @(posedge clk); #1 flags_clr = 1'b1;
        @(posedge clk); #1 flags_clr = 1'b0;
        chk("clr_inv", {31'd0, sticky_invalid}, 32'd0);
        chk("clr_dz", {31'd0, sticky_divzero}, 32'd0);
        set_in(1);
        @(posedge clk); #1 in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("dz_wait", {31'd0, found}, 32'd1);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_with_event", {31'd0, sticky_divzero}, 32'd1);
        @(posedge clk); #1;
        chk("clr_alone", {31'd0, sticky_divzero}, 32'd0);
        flags_clr = 1'b0;

        // Reset with both stages full and the output stalled.
        out_ready = 1'b0;
        set_in(1);
        @(posedge clk); #1 set_in(2);
        @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_flush", {31'd0, out_valid}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rst_no_out", {31'd0, out_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
